// File: rtl/instr_loader.sv
// Byte-stream loader for the 32-entry instruction memory: packs bytes MSB-first
// into 32-bit words and writes them sequentially while holding the CPU.
module instr_loader #(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] load_len,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic [ADDR_W-1:0] word_count,
    output logic              overflow
);

    typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;

    state_t            state, next_state;
    logic [1:0]        byte_cnt;
    logic [ADDR_W-1:0] len_q;
    logic [ADDR_W-1:0] len_clamped;
    logic              start_ok;
    logic              accept;
    logic              last_word;
    logic              byte_ready_d, mem_we_d, cpu_hold_d, done_d, overflow_d;

    assign len_clamped = (load_len > ADDR_W'(DEPTH)) ? ADDR_W'(DEPTH) : load_len;
    assign start_ok    = start && !abort && (state == IDLE || state == DONE);
    assign accept      = (state == LOAD) && byte_valid && byte_ready;
    assign last_word   = (word_count + ADDR_W'(1)) == len_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            byte_ready <= 1'b0;
            mem_we     <= 1'b0;
            cpu_hold   <= 1'b0;
            done       <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            state      <= next_state;
            byte_ready <= byte_ready_d;
            mem_we     <= mem_we_d;
            cpu_hold   <= cpu_hold_d;
            done       <= done_d;
            overflow   <= overflow_d;
        end
    end

    always_comb begin
        next_state = state;
        if (abort) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE, DONE: if (start) next_state = (len_clamped == '0) ? DONE : LOAD;
                LOAD:       if (accept && byte_cnt == 2'd3) next_state = WRITE;
                WRITE:      next_state = last_word ? DONE : LOAD;
                default:    next_state = IDLE;
            endcase
        end
    end

    // Outputs are registered, so they are derived from the state we are entering.
    always_comb begin
        byte_ready_d = (next_state == LOAD);
        mem_we_d     = (next_state == WRITE);
        cpu_hold_d   = (next_state == LOAD) || (next_state == WRITE);
        done_d       = (next_state == DONE);
        overflow_d   = overflow;
        if (abort || start_ok) begin
            overflow_d = 1'b0;
        end else if (state == DONE && byte_valid) begin
            overflow_d = 1'b1;
        end
    end

    // An abort drops the partial word but keeps address and count of written words.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt   <= '0;
            len_q      <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            word_count <= '0;
        end else if (abort) begin
            byte_cnt <= '0;
        end else if (start_ok) begin
            len_q      <= len_clamped;
            mem_addr   <= '0;
            word_count <= '0;
            byte_cnt   <= '0;
        end else if (accept) begin
            mem_wdata <= {mem_wdata[23:0], byte_data};
            byte_cnt  <= byte_cnt + 2'd1;
        end else if (state == WRITE) begin
            mem_addr   <= mem_addr + ADDR_W'(1);
            word_count <= word_count + ADDR_W'(1);
            byte_cnt   <= '0;
        end
    end

endmodule

// File: tb/tb_instr_loader.sv
// Directed self-checking bench for instr_loader; a monitor logs every memory write.
module tb_instr_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [5:0]  load_len;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        mem_we;
    logic [5:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_hold;
    logic        done;
    logic [5:0]  word_count;
    logic        overflow;

    int n_checks = 0;
    int n_fail   = 0;

    int          wr_n = 0;
    int          cyc  = 0;
    logic [5:0]  wr_addr [256];
    logic [31:0] wr_data [256];
    int          wr_cyc  [256];

    instr_loader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .load_len   (load_len),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .word_count (word_count),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (mem_we && wr_n < 256) begin
            wr_addr[wr_n] = mem_addr;
            wr_data[wr_n] = mem_wdata;
            wr_cyc[wr_n]  = cyc;
            wr_n = wr_n + 1;
        end
    end

    task automatic start_load(input logic [5:0] len);
        start    = 1'b1;
        load_len = len;
        @(negedge clk);
        start    = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit ok = 0;
        byte_valid = 1'b1;
        byte_data  = b;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            if (byte_ready) begin
                ok = 1;
                break;
            end
        end
        @(negedge clk);
        byte_valid = 1'b0;
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_byte timeout: byte %h never accepted", b);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; load_len = '0;
        byte_valid = 1'b0; byte_data = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({byte_ready, mem_we, cpu_hold, done, overflow} !== 5'b0 ||
            mem_addr !== 6'd0 || mem_wdata !== 32'd0 || word_count !== 6'd0) begin
            n_fail++;
            $display("FAIL reset_values: got rdy=%b we=%b hold=%b done=%b ovf=%b addr=%h data=%h cnt=%h, required all zero",
                     byte_ready, mem_we, cpu_hold, done, overflow, mem_addr, mem_wdata, word_count);
        end
    endtask

    task automatic test_basic();
        logic [7:0] bytes [8] = '{8'h20, 8'h02, 8'h00, 8'h05, 8'h20, 8'h07, 8'h00, 8'h03};
        int base = wr_n;
        start_load(6'd2);
        n_checks++;
        if (cpu_hold !== 1'b1 || byte_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_hold: got hold=%b rdy=%b, required 1 1", cpu_hold, byte_ready);
        end
        for (int i = 0; i < 4; i++) send_byte(bytes[i]);
        n_checks++;
        if (mem_we !== 1'b1 || mem_addr !== 6'd0 || mem_wdata !== 32'h20020005 || byte_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_word0: got we=%b addr=%h data=%h rdy=%b, required 1 00 20020005 0",
                     mem_we, mem_addr, mem_wdata, byte_ready);
        end
        for (int i = 4; i < 8; i++) send_byte(bytes[i]);
        n_checks++;
        if (mem_we !== 1'b1 || mem_addr !== 6'd1 || mem_wdata !== 32'h20070003) begin
            n_fail++;
            $display("FAIL basic_word1: got we=%b addr=%h data=%h, required 1 01 20070003",
                     mem_we, mem_addr, mem_wdata);
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b1 || word_count !== 6'd2 || cpu_hold !== 1'b0 || mem_we !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_done: got done=%b cnt=%0d hold=%b we=%b, required 1 2 0 0",
                     done, word_count, cpu_hold, mem_we);
        end
        n_checks++;
        if (wr_n - base !== 2) begin
            n_fail++;
            $display("FAIL basic_write_count: got %0d writes, required 2", wr_n - base);
        end
    endtask

    task automatic test_back_to_back();
        int d;
        d = (wr_n >= 2) ? wr_cyc[wr_n-1] - wr_cyc[wr_n-2] : -1;
        n_checks++;
        if (d !== 5) begin
            n_fail++;
            $display("FAIL back_to_back_spacing: got %0d cycles between writes, required 5", d);
        end
    endtask

    task automatic test_gaps();
        logic [7:0] bytes [4] = '{8'h00, 8'hE2, 8'h20, 8'h25};
        int base = wr_n;
        start_load(6'd1);
        for (int i = 0; i < 4; i++) begin
            send_byte(bytes[i]);
            if (i < 3) @(negedge clk);
        end
        repeat (2) @(negedge clk);
        n_checks++;
        if (wr_n - base !== 1) begin
            n_fail++;
            $display("FAIL gaps_write_count: got %0d writes, required 1", wr_n - base);
        end else begin
            n_checks++;
            if (wr_addr[base] !== 6'd0 || wr_data[base] !== 32'h00E22025) begin
                n_fail++;
                $display("FAIL gaps_word: got addr=%h data=%h, required 00 00e22025", wr_addr[base], wr_data[base]);
            end
        end
    endtask

    task automatic test_zero_len();
        int base = wr_n;
        start_load(6'd0);
        n_checks++;
        if (done !== 1'b1 || cpu_hold !== 1'b0 || mem_we !== 1'b0 || word_count !== 6'd0) begin
            n_fail++;
            $display("FAIL zero_len: got done=%b hold=%b we=%b cnt=%0d, required 1 0 0 0",
                     done, cpu_hold, mem_we, word_count);
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (wr_n - base !== 0) begin
            n_fail++;
            $display("FAIL zero_len_writes: got %0d writes, required 0", wr_n - base);
        end
    endtask

    task automatic test_clamp();
        int base = wr_n;
        logic [31:0] expw;
        start_load(6'd40);
        for (int w = 0; w < 32; w++)
            for (int b = 0; b < 4; b++) send_byte(8'(w * 4 + b));
        repeat (2) @(negedge clk);
        n_checks++;
        if (wr_n - base !== 32 || word_count !== 6'd32 || done !== 1'b1) begin
            n_fail++;
            $display("FAIL clamp_total: got writes=%0d cnt=%0d done=%b, required 32 32 1",
                     wr_n - base, word_count, done);
        end
        for (int w = 0; w < 32 && base + w < wr_n; w++) begin
            expw = {8'(w*4), 8'(w*4+1), 8'(w*4+2), 8'(w*4+3)};
            n_checks++;
            if (wr_addr[base+w] !== 6'(w) || wr_data[base+w] !== expw) begin
                n_fail++;
                $display("FAIL clamp_word%0d: got addr=%h data=%h, required %h %h",
                         w, wr_addr[base+w], wr_data[base+w], 6'(w), expw);
            end
        end
    endtask

    task automatic test_abort();
        int base = wr_n;
        start_load(6'd3);
        for (int i = 0; i < 6; i++) send_byte(8'hA0 + 8'(i));
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        n_checks++;
        if (cpu_hold !== 1'b0 || done !== 1'b0 || byte_ready !== 1'b0 || word_count !== 6'd1) begin
            n_fail++;
            $display("FAIL abort_state: got hold=%b done=%b rdy=%b cnt=%0d, required 0 0 0 1",
                     cpu_hold, done, byte_ready, word_count);
        end
        byte_valid = 1'b1;
        repeat (8) @(negedge clk);
        byte_valid = 1'b0;
        n_checks++;
        if (wr_n - base !== 1 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_no_write: got writes=%0d ovf=%b, required 1 0", wr_n - base, overflow);
        end
    endtask

    task automatic test_overflow();
        int base;
        start_load(6'd1);
        for (int i = 0; i < 4; i++) send_byte(8'h11 * 8'(i + 1));
        @(negedge clk);
        base = wr_n;
        byte_valid = 1'b1;
        @(negedge clk);
        byte_valid = 1'b0;
        n_checks++;
        if (overflow !== 1'b1 || done !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow_set: got ovf=%b done=%b, required 1 1", overflow, done);
        end
        repeat (2) @(negedge clk);
        n_checks++;
        if (overflow !== 1'b1 || wr_n - base !== 0) begin
            n_fail++;
            $display("FAIL overflow_sticky: got ovf=%b writes=%0d, required 1 0", overflow, wr_n - base);
        end
        start_load(6'd1);
        n_checks++;
        if (overflow !== 1'b0 || done !== 1'b0 || cpu_hold !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow_clear: got ovf=%b done=%b hold=%b, required 0 0 1", overflow, done, cpu_hold);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
    endtask

    task automatic test_async_reset();
        start_load(6'd2);
        for (int i = 0; i < 4; i++) send_byte(8'h5A);
        n_checks++;
        if (mem_we !== 1'b1) begin
            n_fail++;
            $display("FAIL areset_in_write: got we=%b, required 1", mem_we);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (mem_we !== 1'b0 || cpu_hold !== 1'b0 || byte_ready !== 1'b0 || word_count !== 6'd0 || mem_wdata !== 32'd0) begin
            n_fail++;
            $display("FAIL areset_immediate: got we=%b hold=%b rdy=%b cnt=%0d data=%h, required 0 0 0 0 0",
                     mem_we, cpu_hold, byte_ready, word_count, mem_wdata);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (cpu_hold !== 1'b0 || done !== 1'b0 || byte_ready !== 1'b0 || mem_we !== 1'b0) begin
            n_fail++;
            $display("FAIL areset_idle: got hold=%b done=%b rdy=%b we=%b, required 0 0 0 0",
                     cpu_hold, done, byte_ready, mem_we);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_gaps();
        test_zero_len();
        test_clamp();
        test_abort();
        test_overflow();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_loader.md
Name: instr_loader

Overview:
- Write-side companion to the processor's 32-entry instruction memory. It accepts a byte stream from a host or serial front end and assembles bytes into 32-bit big-endian instruction words.
- Each word is written sequentially into instruction memory through a single-port write interface.
- cpu_hold stays asserted while a load is in progress, so the core does not fetch from a partially written program.

Parameters:
- DEPTH, 32, number of instruction words the memory holds; maximum load length.
- ADDR_W, 6, width of the instruction memory address; matches the 6-bit fetch address.

Ports:
- clk  in  1  single system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse that begins a load; honoured only in IDLE or DONE.
- abort  in  1  cancels any load and returns to IDLE; has priority over start.
- load_len  in  ADDR_W  number of words to load; sampled on an accepted start.
- byte_valid  in  1  host byte available.
- byte_data  in  8  host byte.
- byte_ready  out  1  loader accepts byte_data this cycle when byte_valid=1.
- mem_we  out  1  instruction memory write enable, one cycle per word.
- mem_addr  out  ADDR_W  write address.
- mem_wdata  out  32  assembled instruction word.
- cpu_hold  out  1  holds the processor (PC/fetch) while loading.
- done  out  1  level; high after a completed load until the next start or abort.
- word_count  out  ADDR_W  words written in the current/last load.
- overflow  out  1  sticky; byte_valid seen while in DONE. Cleared by start or abort.

Behaviour:
- Reset values (rst_n low, asynchronous): state=IDLE. byte_ready, mem_we, cpu_hold, done, overflow = 0. mem_addr, mem_wdata, word_count = 0. Internal byte counter = 0. Internal length register = 0.
- All outputs are registered; no combinational path from inputs to outputs.
- Length clamp: len_q = (load_len > DEPTH) ? DEPTH : load_len.
- IDLE:
  - byte_ready=0, cpu_hold=0.
  - On start: latch len_q; clear mem_addr, word_count, byte counter, done and overflow; set cpu_hold=1.
  - Then go to DONE if len_q==0, else LOAD.
- LOAD:
  - byte_ready=1, cpu_hold=1.
  - A byte is accepted on byte_valid & byte_ready. It is shifted into the word register MSB-first: the first byte lands in [31:24] and the fourth in [7:0].
  - Byte counter increments on each accepted byte. On the 4th accepted byte, the next state is WRITE and byte_ready drops in that next cycle.
  - byte_valid without acceptance has no effect.
- WRITE:
  - Exactly one cycle with mem_we=1, mem_addr = current address, mem_wdata = assembled word, byte_ready=0.
  - On exit: mem_addr+1, word_count+1, byte counter cleared.
  - If word_count+1 == len_q, go to DONE; otherwise return to LOAD.
- Latency: the 4th byte accepted at edge N gives mem_we high in cycle N+1. Sustained throughput is one word per 5 cycles.
- DONE:
  - cpu_hold=0, done=1, byte_ready=0, mem_we=0.
  - byte_valid=1 in DONE sets overflow (sticky).
  - start restarts exactly as from IDLE and clears done.
- abort in any state: next state IDLE. cpu_hold, done, byte_ready, mem_we and overflow go to 0. The partial word is discarded. Words already written remain in memory, and word_count holds its value.
- start together with abort: abort wins. start in LOAD/WRITE: ignored.
- Address wrap: cannot occur. Clamping guarantees mem_addr never exceeds DEPTH-1 while mem_we=1.
- Reset mid-load: immediate return to reset values. Memory contents are undefined beyond what was already written.

Test Plan:
- Basic load: start with load_len=2, bytes 20,02,00,05,20,07,00,03 → mem_we at addr 0 with 0x20020005, then at addr 1 with 0x20070003. done=1, word_count=2, cpu_hold 1→0.
- Back-pressure/gaps: byte_valid toggled 1/0 every cycle during a 1-word load of 0x00E22025 → exactly one write of 0x00E22025 at addr 0. No byte is duplicated or dropped.
- Zero and clamp: load_len=0 → DONE one cycle after start, no mem_we. load_len=40 → exactly 32 writes (addr 0..31), word_count=32.
- Abort: abort after the 2nd byte of word 1 in a 3-word load → IDLE next cycle, no further mem_we, cpu_hold=0, done=0, word_count=1.
- Overflow: complete a 1-word load, then drive byte_valid=1 → overflow=1 and no write. A subsequent start clears overflow.
- Async reset: assert rst_n=0 mid-WRITE (between clock edges) → mem_we and cpu_hold drop immediately, state=IDLE.
